// File: rtl/eth_apb_regfile_if.sv
// rtl/eth_apb_regfile_if.sv - APB host-port bus bundle for the Ethernet MAC register file
interface eth_apb_regfile_if #(
    parameter int ADDR_W = 10
);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [31:0]       pwdata_i;
    logic [31:0]       prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/eth_apb_regfile.sv
// rtl/eth_apb_regfile.sv - APB register file for the Ethernet MAC host port
module eth_apb_regfile #(
    parameter int          ADDR_W      = 10,
    parameter int          N_INT       = 7,
    parameter int          WAIT_STATES = 0,
    parameter int          TX_BD_MAX   = 128,
    parameter logic [31:0] MODER_RST   = 32'h0000A000
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    eth_apb_regfile_if.slave  apb,
    input  logic [N_INT-1:0]  int_src_i,
    output logic [31:0]       moder_o,
    output logic [7:0]        tx_bd_num_o,
    output logic [4:0]        mii_fiad_o,
    output logic [4:0]        mii_rgad_o,
    output logic [47:0]       mac_addr_o,
    output logic              int_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [ADDR_W-1:0] A_MODER    = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_INT_SRC  = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_INT_MASK = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_TX_BD    = ADDR_W'(32'h20);
    localparam logic [ADDR_W-1:0] A_MII      = ADDR_W'(32'h30);
    localparam logic [ADDR_W-1:0] A_MAC0     = ADDR_W'(32'h40);
    localparam logic [ADDR_W-1:0] A_MAC1     = ADDR_W'(32'h44);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_moder;
    logic [N_INT-1:0]  r_int_src;
    logic [N_INT-1:0]  r_int_mask;
    logic [7:0]        r_tx_bd;
    logic [4:0]        r_mii_fiad;
    logic [4:0]        r_mii_rgad;
    logic [31:0]       r_mac0;
    logic [15:0]       r_mac1;
    logic              r_int;

    logic              w_setup;
    logic              w_enter_resp;
    logic              w_commit;
    logic [ADDR_W-1:0] w_dec_addr;
    logic              w_dec_write;
    logic [31:0]       w_dec_wdata;
    logic              w_hit;
    logic              w_err;
    logic [31:0]       w_rd;
    logic [N_INT-1:0]  w_w1c;

    assign w_setup = (r_state == ST_IDLE) && apb.psel_i && !apb.penable_i;

    // With zero wait states the response is decoded straight off the bus in the SETUP cycle.
    assign w_dec_addr  = (r_state == ST_IDLE) ? apb.paddr_i  : r_addr;
    assign w_dec_write = (r_state == ST_IDLE) ? apb.pwrite_i : r_write;
    assign w_dec_wdata = (r_state == ST_IDLE) ? apb.pwdata_i : r_wdata;

    assign w_enter_resp = (w_setup && (WAIT_STATES == 0)) ||
                          ((r_state == ST_WAIT) && apb.psel_i && (r_cnt == 4'd0));

    assign w_commit = (r_state == ST_RESP) && apb.psel_i && apb.penable_i &&
                      apb.pwrite_i && r_write && !r_err;

    always_comb begin
        w_hit = 1'b1;
        w_rd  = 32'h0;
        case (w_dec_addr)
            A_MODER:    w_rd = r_moder;
            A_INT_SRC:  w_rd = 32'(r_int_src);
            A_INT_MASK: w_rd = 32'(r_int_mask);
            A_TX_BD:    w_rd = {24'h0, r_tx_bd};
            A_MII:      w_rd = {19'h0, r_mii_rgad, 3'h0, r_mii_fiad};
            A_MAC0:     w_rd = r_mac0;
            A_MAC1:     w_rd = {16'h0, r_mac1};
            default:    w_hit = 1'b0;
        endcase
        w_err = !w_hit || (w_dec_addr[1:0] != 2'b00) ||
                (w_dec_write && (w_dec_addr == A_TX_BD) && (w_dec_wdata > 32'(TX_BD_MAX)));
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_enter_resp) begin
                r_rdata <= w_rd;
                r_err   <= w_err;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_addr  <= apb.paddr_i;
                        r_write <= apb.pwrite_i;
                        r_wdata <= apb.pwdata_i;
                        r_cnt   <= CNT_INIT;
                        r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!apb.psel_i)          r_state <= ST_IDLE;
                    else if (r_cnt == 4'd0)   r_state <= ST_RESP;
                    else                      r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A fresh event on the same edge as a W1C keeps the bit set.
    assign w_w1c = (w_commit && (r_addr == A_INT_SRC)) ? r_wdata[N_INT-1:0] : '0;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_moder    <= MODER_RST;
            r_int_src  <= '0;
            r_int_mask <= '0;
            r_tx_bd    <= 8'h40;
            r_mii_fiad <= 5'h0;
            r_mii_rgad <= 5'h0;
            r_mac0     <= 32'h0;
            r_mac1     <= 16'h0;
            r_int      <= 1'b0;
        end else begin
            r_int_src <= (r_int_src & ~w_w1c) | int_src_i;
            r_int     <= |(r_int_src & r_int_mask);
            if (w_commit) begin
                case (r_addr)
                    A_MODER:    r_moder    <= r_wdata;
                    A_INT_MASK: r_int_mask <= r_wdata[N_INT-1:0];
                    A_TX_BD:    r_tx_bd    <= r_wdata[7:0];
                    A_MII: begin
                        r_mii_fiad <= r_wdata[4:0];
                        r_mii_rgad <= r_wdata[12:8];
                    end
                    A_MAC0:     r_mac0     <= r_wdata;
                    A_MAC1:     r_mac1     <= r_wdata[15:0];
                    default:    ;
                endcase
            end
        end
    end

    assign apb.pready_o  = (r_state == ST_RESP) && apb.psel_i;
    assign apb.pslverr_o = apb.pready_o && r_err;
    assign apb.prdata_o  = apb.pready_o ? r_rdata : 32'h0;

    assign moder_o     = r_moder;
    assign tx_bd_num_o = r_tx_bd;
    assign mii_fiad_o  = r_mii_fiad;
    assign mii_rgad_o  = r_mii_rgad;
    assign mac_addr_o  = {r_mac1, r_mac0};
    assign int_o       = r_int;
endmodule

// File: tb/tb_eth_apb_regfile.sv
// tb/tb_eth_apb_regfile.sv - scoreboard bench for eth_apb_regfile, zero- and three-wait-state instances
module tb_eth_apb_regfile;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_sel;
    logic        m_psel;
    logic        m_pen;
    logic        m_pwr;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [6:0]  m_int;
    int          n_tests = 0;
    int          n_fail  = 0;

    eth_apb_regfile_if #(.ADDR_W(10)) bus0 ();
    eth_apb_regfile_if #(.ADDR_W(10)) bus3 ();

    assign bus0.psel_i    = m_psel & ~m_sel;
    assign bus0.penable_i = m_pen;
    assign bus0.pwrite_i  = m_pwr;
    assign bus0.paddr_i   = m_addr;
    assign bus0.pwdata_i  = m_wdata;
    assign bus3.psel_i    = m_psel & m_sel;
    assign bus3.penable_i = m_pen;
    assign bus3.pwrite_i  = m_pwr;
    assign bus3.paddr_i   = m_addr;
    assign bus3.pwdata_i  = m_wdata;

    logic [6:0]  int0, int3;
    logic [31:0] moder0, moder3;
    logic [7:0]  txbd0, txbd3;
    logic [4:0]  fiad0, fiad3, rgad0, rgad3;
    logic [47:0] mac0, mac3;
    logic        irq0, irq3;

    assign int0 = m_sel ? 7'h0 : m_int;
    assign int3 = m_sel ? m_int : 7'h0;

    eth_apb_regfile #(.WAIT_STATES(0)) u_dut0 (
        .pclk_i(clk), .prst_i(rst), .apb(bus0.slave), .int_src_i(int0),
        .moder_o(moder0), .tx_bd_num_o(txbd0), .mii_fiad_o(fiad0),
        .mii_rgad_o(rgad0), .mac_addr_o(mac0), .int_o(irq0)
    );

    eth_apb_regfile #(.WAIT_STATES(3)) u_dut3 (
        .pclk_i(clk), .prst_i(rst), .apb(bus3.slave), .int_src_i(int3),
        .moder_o(moder3), .tx_bd_num_o(txbd3), .mii_fiad_o(fiad3),
        .mii_rgad_o(rgad3), .mac_addr_o(mac3), .int_o(irq3)
    );

    logic        w_rdy;
    logic        w_err;
    logic [31:0] w_rdata;
    assign w_rdy   = m_sel ? bus3.pready_o  : bus0.pready_o;
    assign w_err   = m_sel ? bus3.pslverr_o : bus0.pslverr_o;
    assign w_rdata = m_sel ? bus3.prdata_o  : bus0.prdata_o;

    typedef struct {
        string       tag;
        logic        wr;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic sel, input logic wr, input logic [9:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_rd,
                            input logic exp_err, input string tag,
                            input logic [6:0] resp_int = 7'h0);
        exp_t e;
        int   cyc;
        e.tag = tag; e.wr = wr; e.rd = exp_rd; e.err = exp_err;
        e.lat = sel ? 4 : 1;
        sb.push_back(e);
        @(posedge clk); #1;
        m_sel = sel; m_psel = 1'b1; m_pen = 1'b0; m_pwr = wr; m_addr = addr; m_wdata = data;
        @(posedge clk); #1;
        m_pen = 1'b1;
        cyc = 1;
        while (!w_rdy && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        if (!w_rdy) begin
            check_val({e.tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check_val({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
            check_val({e.tag, "_err"}, 64'(w_err), 64'(e.err));
            if (!e.wr) check_val({e.tag, "_rd"}, 64'(w_rdata), 64'(e.rd));
        end
        m_int = resp_int;
        @(posedge clk); #1;
        m_int = 7'h0; m_psel = 1'b0; m_pen = 1'b0;
    endtask

    task automatic pulse_int(input logic [6:0] v);
        @(posedge clk); #1;
        m_int = v;
        @(posedge clk); #1;
        m_int = 7'h0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; m_sel = 1'b0; m_psel = 1'b0; m_pen = 1'b0; m_pwr = 1'b0;
        m_addr = '0; m_wdata = '0; m_int = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pready", 64'(bus0.pready_o), 64'd0);
        check_val("rst_prdata", 64'(bus0.prdata_o), 64'd0);
        check_val("rst_moder", 64'(moder0), 64'h0000A000);
        check_val("rst_txbd", 64'(txbd0), 64'h40);
        check_val("rst_irq", 64'(irq0), 64'd0);
        rst = 1'b0;

        apb_xfer(0, 0, 10'h000, 0, 32'h0000A000, 0, "rd_moder");
        apb_xfer(0, 0, 10'h004, 0, 32'h0, 0, "rd_intsrc");
        apb_xfer(0, 0, 10'h008, 0, 32'h0, 0, "rd_intmask");
        apb_xfer(0, 0, 10'h020, 0, 32'h40, 0, "rd_txbd");
        apb_xfer(0, 0, 10'h030, 0, 32'h0, 0, "rd_mii");
        apb_xfer(0, 0, 10'h040, 0, 32'h0, 0, "rd_mac0");
        apb_xfer(0, 0, 10'h044, 0, 32'h0, 0, "rd_mac1");

        apb_xfer(0, 1, 10'h020, 32'h81, 0, 1, "wr_txbd_81");
        check_val("txbd_keep", 64'(txbd0), 64'h40);
        apb_xfer(0, 0, 10'h020, 0, 32'h40, 0, "rd_txbd_keep");
        apb_xfer(0, 1, 10'h020, 32'h80, 0, 0, "wr_txbd_80");
        check_val("txbd_80", 64'(txbd0), 64'h80);
        apb_xfer(0, 0, 10'h010, 0, 32'h0, 1, "rd_unmapped");
        apb_xfer(0, 0, 10'h002, 0, 32'h0, 1, "rd_unaligned");

        pulse_int(7'h04);
        apb_xfer(0, 0, 10'h004, 0, 32'h4, 0, "rd_intsrc_set");
        check_val("irq_masked", 64'(irq0), 64'd0);
        apb_xfer(0, 1, 10'h008, 32'h4, 0, 0, "wr_mask");
        check_val("irq_before", 64'(irq0), 64'd0);
        @(posedge clk); #1;
        check_val("irq_after", 64'(irq0), 64'd1);
        apb_xfer(0, 1, 10'h004, 32'h4, 0, 0, "w1c");
        apb_xfer(0, 0, 10'h004, 0, 32'h0, 0, "rd_intsrc_clr");
        check_val("irq_clr", 64'(irq0), 64'd0);
        apb_xfer(0, 1, 10'h004, 32'h4, 0, 0, "w1c_race", 7'h04);
        apb_xfer(0, 0, 10'h004, 0, 32'h4, 0, "rd_intsrc_race");
        check_val("irq_race", 64'(irq0), 64'd1);

        apb_xfer(1, 1, 10'h040, 32'h11223344, 0, 0, "wr_mac0");
        apb_xfer(1, 1, 10'h044, 32'hFFFF5566, 0, 0, "wr_mac1");
        check_val("mac_addr", 64'(mac3), 64'h556611223344);
        apb_xfer(1, 0, 10'h044, 0, 32'h00005566, 0, "rd_mac1_mask");

        @(posedge clk); #1;
        m_sel = 1'b1; m_psel = 1'b1; m_pen = 1'b0; m_pwr = 1'b1; m_addr = 10'h030; m_wdata = 32'h00000A05;
        @(posedge clk); #1;
        m_pen = 1'b1;
        @(posedge clk); #1;
        m_psel = 1'b0; m_pen = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | bus3.pready_o;
        end
        check_val("abort_pready", 64'(seen), 64'd0);
        apb_xfer(1, 0, 10'h030, 0, 32'h0, 0, "rd_mii_abort");
        check_val("abort_fiad", 64'(fiad3), 64'd0);
        apb_xfer(1, 1, 10'h030, 32'hFFFFFFFF, 0, 0, "wr_mii_all");
        apb_xfer(1, 0, 10'h030, 0, 32'h00001F1F, 0, "rd_mii_mask");
        check_val("mii_fiad", 64'(fiad3), 64'h1F);
        check_val("mii_rgad", 64'(rgad3), 64'h1F);

        @(posedge clk); #1;
        m_sel = 1'b1; m_psel = 1'b1; m_pen = 1'b0; m_pwr = 1'b1; m_addr = 10'h000; m_wdata = 32'h1;
        @(posedge clk); #1;
        m_pen = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("rst_mid_pready", 64'(bus3.pready_o), 64'd0);
        @(posedge clk); #1;
        m_psel = 1'b0; m_pen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_moder", 64'(moder3), 64'h0000A000);
        check_val("rst_mid_txbd0", 64'(txbd0), 64'h40);
        apb_xfer(1, 0, 10'h000, 0, 32'h0000A000, 0, "rd_moder_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
